// File: rtl/otsu_thresh_core.sv
// Otsu threshold core: per-frame grey histogram, between-class-variance scan in blanking.
// Optional OTSU_BIN_OUT_EN adds a registered binarised pixel output with delayed syncs.
`timescale 1ns/1ps
module otsu_thresh_core #(
  parameter int PIX_W = 8,
  parameter int CNT_W = 20,
  parameter int SUM_W = CNT_W + PIX_W
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] iGray_orig,
  input  logic             hs,
  input  logic             vs,
  input  logic             de,
  output logic [PIX_W-1:0] oThresh,
  output logic             oThresh_valid,
  output logic             oDegenerate,
  output logic             oBusy,
  output logic             oDrop
`ifdef OTSU_BIN_OUT_EN
  ,
  output logic [PIX_W-1:0] oBin,
  output logic             oHs,
  output logic             oVs,
  output logic             oDe
`endif
);
  localparam int BINS   = 1 << PIX_W;
  localparam int PRD_W  = SUM_W + CNT_W;
  localparam int NUM_W  = 2 * PRD_W;
  localparam int DEN_W  = 2 * CNT_W;
  localparam int CMP_W  = NUM_W + DEN_W;
  localparam int STAGES = 2;
  localparam logic [PIX_W-1:0] LAST_BIN = PIX_W'(BINS - 1);

  typedef enum logic [1:0] {CLEAR, ACCUM, SCAN} st_e;
  st_e state_q;

  logic [CNT_W-1:0] hist_q [BINS];
  logic [CNT_W-1:0] rd_q, last_wr_q, n_q, w0_q, base, inc, w1;
  logic [SUM_W-1:0] sumT_q, s0_q;
  logic [PIX_W-1:0] clr_addr_q, p1_pix_q, t_iss_q, t0_q, t1_q, t2_q, rd_addr;
  logic [PIX_W-1:0] thr_q, best_t_q, best_t_d;
  logic             p1_vld_q, fwd_q, vs_q, busy_q, drop_q, thr_vld_q, degen_q;
  logic             pro_q, iss_on_q, cand_q, found_q, found_d, upd, acc, iss, vs_rise;
  logic [STAGES:0]  vld_pipe;
  logic [PRD_W-1:0] prod_a, prod_b, diff_q;
  logic [DEN_W-1:0] den_q, best_den_q;
  logic [NUM_W-1:0] num, best_num_q;
  logic [CMP_W-1:0] lhs, rhs;

  assign vs_rise = vs & ~vs_q;
  assign acc     = de && (state_q == ACCUM);
  assign iss     = (state_q == SCAN) && !pro_q && iss_on_q;
  assign rd_addr = (state_q == SCAN) ? t_iss_q : iGray_orig;

  // Back-to-back hits on the same bin take the value written last cycle, not the stale read.
  assign base = fwd_q ? last_wr_q : rd_q;
  assign inc  = (&base) ? base : base + CNT_W'(1);

  assign w1     = n_q - w0_q;
  assign prod_a = PRD_W'(sumT_q) * PRD_W'(w0_q);
  assign prod_b = PRD_W'(n_q) * PRD_W'(s0_q);

  // Cross-multiplied ratio compare at full width; strict so the lowest t keeps ties.
  assign num      = NUM_W'(diff_q) * NUM_W'(diff_q);
  assign lhs      = CMP_W'(num) * CMP_W'(best_den_q);
  assign rhs      = CMP_W'(best_num_q) * CMP_W'(den_q);
  assign upd      = vld_pipe[2] && cand_q && (lhs > rhs);
  assign best_t_d = upd ? t2_q : best_t_q;
  assign found_d  = found_q | upd;

  always_ff @(posedge clock) begin
    if (state_q == CLEAR)  hist_q[clr_addr_q] <= '0;
    else if (p1_vld_q)     hist_q[p1_pix_q]   <= inc;
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      {vs_q, busy_q, drop_q, thr_vld_q, degen_q, p1_vld_q, fwd_q} <= '0;
      {pro_q, iss_on_q, cand_q, found_q} <= '0;
      {rd_q, last_wr_q, n_q, w0_q, sumT_q, s0_q} <= '0;
      {clr_addr_q, p1_pix_q, t_iss_q, t0_q, t1_q, t2_q, thr_q, best_t_q} <= '0;
      {diff_q, den_q, best_den_q, best_num_q} <= '0;
      vld_pipe <= '0;
    end else begin
      vs_q      <= vs;
      thr_vld_q <= 1'b0;
      rd_q      <= hist_q[rd_addr];
      if (vs_rise)           drop_q <= 1'b0;
      else if (de && busy_q) drop_q <= 1'b1;

      p1_vld_q <= acc;
      p1_pix_q <= iGray_orig;
      fwd_q    <= acc && p1_vld_q && (p1_pix_q == iGray_orig);
      if (p1_vld_q) last_wr_q <= inc;
      if (acc) begin
        n_q    <= n_q + CNT_W'(1);
        sumT_q <= sumT_q + SUM_W'(iGray_orig);
      end

      vld_pipe <= {vld_pipe[STAGES-1:0], iss};
      t0_q <= t_iss_q;
      t1_q <= t0_q;
      t2_q <= t1_q;
      if (vld_pipe[0]) begin
        w0_q <= w0_q + rd_q;
        s0_q <= s0_q + SUM_W'(t0_q) * SUM_W'(rd_q);
      end
      cand_q <= (w0_q != '0) && (w1 != '0);
      diff_q <= (prod_a >= prod_b) ? prod_a - prod_b : prod_b - prod_a;
      den_q  <= DEN_W'(w0_q) * DEN_W'(w1);
      if (upd) begin
        best_num_q <= num;
        best_den_q <= den_q;
        best_t_q   <= t2_q;
        found_q    <= 1'b1;
      end

      case (state_q)
        CLEAR: begin
          busy_q     <= 1'b1;
          clr_addr_q <= clr_addr_q + PIX_W'(1);
          if (clr_addr_q == LAST_BIN) begin
            state_q <= ACCUM;
            busy_q  <= 1'b0;
          end
        end
        ACCUM: begin
          if (vs_rise && ((n_q != '0) || acc)) begin
            state_q    <= SCAN;
            busy_q     <= 1'b1;
            pro_q      <= 1'b1;
            iss_on_q   <= 1'b1;
            t_iss_q    <= '0;
            w0_q       <= '0;
            s0_q       <= '0;
            best_num_q <= '0;
            best_den_q <= DEN_W'(1);
            best_t_q   <= '0;
            found_q    <= 1'b0;
          end
        end
        SCAN: begin
          // One idle cycle lets the last accumulated pixel land before bin 0 is read.
          if (pro_q) pro_q <= 1'b0;
          else if (iss_on_q) begin
            if (t_iss_q == LAST_BIN) iss_on_q <= 1'b0;
            else                     t_iss_q  <= t_iss_q + PIX_W'(1);
          end
          if (vld_pipe[2] && (t2_q == LAST_BIN)) begin
            if (found_d) thr_q <= best_t_d;
            thr_vld_q  <= 1'b1;
            degen_q    <= !found_d;
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            n_q        <= '0;
            sumT_q     <= '0;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign oThresh       = thr_q;
  assign oThresh_valid = thr_vld_q;
  assign oDegenerate   = degen_q;
  assign oBusy         = busy_q;
  assign oDrop         = drop_q;

`ifdef OTSU_BIN_OUT_EN
  logic [PIX_W-1:0] bin_q;
  logic             hs_q, vsd_q, de_q;
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      bin_q <= '0;
      {hs_q, vsd_q, de_q} <= '0;
    end else begin
      bin_q <= (iGray_orig > thr_q) ? '1 : '0;
      hs_q  <= hs;
      vsd_q <= vs;
      de_q  <= de;
    end
  end
  assign oBin = bin_q;
  assign oHs  = hs_q;
  assign oVs  = vsd_q;
  assign oDe  = de_q;
`else
  logic unused_hs;
  assign unused_hs = hs;
`endif
endmodule

// File: tb/tb_otsu_thresh_core.sv
// Directed self-checking bench for otsu_thresh_core (PIX_W=8, CNT_W=20).
`timescale 1ns/1ps
module tb_otsu_thresh_core;
  logic       clock = 1'b0, rst_n = 1'b0;
  logic [7:0] iGray_orig = '0;
  logic       hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic [7:0] oThresh;
  logic       oThresh_valid, oDegenerate, oBusy, oDrop;
`ifdef OTSU_BIN_OUT_EN
  logic [7:0] oBin;
  logic       oHs, oVs, oDe;
`endif
  int n_chk = 0, n_fail = 0;

  always #5 clock = ~clock;

  otsu_thresh_core #(.PIX_W(8), .CNT_W(20)) dut (
    .clock(clock), .rst_n(rst_n), .iGray_orig(iGray_orig), .hs(hs), .vs(vs), .de(de),
    .oThresh(oThresh), .oThresh_valid(oThresh_valid), .oDegenerate(oDegenerate),
    .oBusy(oBusy), .oDrop(oDrop)
`ifdef OTSU_BIN_OUT_EN
    , .oBin(oBin), .oHs(oHs), .oVs(oVs), .oDe(oDe)
`endif
  );

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; de = 1'b0; vs = 1'b0; hs = 1'b0;
    tick(); tick();
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      if (!oBusy) begin ok = 1'b1; break; end
      tick();
    end
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL idle_timeout: busy=%0b required 0", oBusy); end
  endtask

  task automatic send_px(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin iGray_orig = v; de = 1'b1; tick(); end
    de = 1'b0; tick(); tick();
  endtask

  task automatic vs_pulse();
    vs = 1'b1; tick(); vs = 1'b0;
  endtask

  task automatic wait_pulse(output int pulses, output int lat, output logic [7:0] th,
                            output logic dg);
    pulses = 0; lat = -1; th = 'x; dg = 'x;
    for (int c = 1; c <= 600; c++) begin
      tick();
      if (oThresh_valid) begin
        pulses++;
        if (lat < 0) begin lat = c; th = oThresh; dg = oDegenerate; end
      end
    end
  endtask

  task automatic frame(input logic [7:0] a, input int na, input logic [7:0] b, input int nb,
                       output int pulses, output int lat, output logic [7:0] th,
                       output logic dg);
    wait_idle();
    send_px(a, na);
    send_px(b, nb);
    vs_pulse();
    wait_pulse(pulses, lat, th, dg);
  endtask

  task automatic test_reset();
    do_reset();
    n_chk += 5;
    if (oThresh !== 8'd0)     begin n_fail++; $display("FAIL rst_thresh: got %0d want 0", oThresh); end
    if (oThresh_valid !== 0)  begin n_fail++; $display("FAIL rst_valid: got %b want 0", oThresh_valid); end
    if (oDegenerate !== 0)    begin n_fail++; $display("FAIL rst_degen: got %b want 0", oDegenerate); end
    if (oBusy !== 0)          begin n_fail++; $display("FAIL rst_busy: got %b want 0", oBusy); end
    if (oDrop !== 0)          begin n_fail++; $display("FAIL rst_drop: got %b want 0", oDrop); end
    rst_n = 1'b1; tick();
    n_chk++;
    if (oBusy !== 1'b1) begin n_fail++; $display("FAIL rst_clear_busy: got %b want 1", oBusy); end
  endtask

  task automatic test_bimodal();
    int p, l; logic [7:0] th; logic dg;
    frame(8'd20, 8, 8'd200, 8, p, l, th, dg);
    n_chk += 4;
    if (th !== 8'd20) begin n_fail++; $display("FAIL bimodal_thresh: got %0d want 20", th); end
    if (p != 1)       begin n_fail++; $display("FAIL bimodal_pulses: got %0d want 1", p); end
    if (dg !== 1'b0)  begin n_fail++; $display("FAIL bimodal_degen: got %b want 0", dg); end
    if (l < 1 || l > 520) begin n_fail++; $display("FAIL bimodal_latency: got %0d want 1..520", l); end
  endtask

  task automatic test_hazard();
    int p, l; logic [7:0] th; logic dg;
    wait_idle();
    send_px(8'd10, 12);
    send_px(8'd250, 4);
    n_chk += 3;
    if (dut.n_q !== 20'd16)         begin n_fail++; $display("FAIL hazard_n: got %0d want 16", dut.n_q); end
    if (dut.hist_q[10] !== 20'd12)  begin n_fail++; $display("FAIL hazard_h10: got %0d want 12", dut.hist_q[10]); end
    if (dut.hist_q[250] !== 20'd4)  begin n_fail++; $display("FAIL hazard_h250: got %0d want 4", dut.hist_q[250]); end
    vs_pulse();
    wait_pulse(p, l, th, dg);
    n_chk += 2;
    if (th !== 8'd10) begin n_fail++; $display("FAIL hazard_thresh: got %0d want 10", th); end
    if (dg !== 1'b0)  begin n_fail++; $display("FAIL hazard_degen: got %b want 0", dg); end
  endtask

  task automatic test_uniform();
    int p, l; logic [7:0] th; logic dg;
    do_reset(); rst_n = 1'b1; tick();
    frame(8'd77, 8, 8'd77, 8, p, l, th, dg);
    n_chk += 3;
    if (th !== 8'd0) begin n_fail++; $display("FAIL uniform_thresh: got %0d want 0", th); end
    if (p != 1)      begin n_fail++; $display("FAIL uniform_pulses: got %0d want 1", p); end
    if (dg !== 1'b1) begin n_fail++; $display("FAIL uniform_degen: got %b want 1", dg); end
    frame(8'd20, 8, 8'd200, 8, p, l, th, dg);
    n_chk += 2;
    if (th !== 8'd20) begin n_fail++; $display("FAIL after_uniform_thresh: got %0d want 20", th); end
    if (dg !== 1'b0)  begin n_fail++; $display("FAIL after_uniform_degen: got %b want 0", dg); end
  endtask

  task automatic test_drop();
    int p, l; logic [7:0] th; logic dg;
    wait_idle();
    send_px(8'd20, 8);
    send_px(8'd200, 8);
    vs_pulse();
    tick(); tick(); tick(); tick();
    iGray_orig = 8'd5; de = 1'b1; tick(); de = 1'b0;
    n_chk += 3;
    if (oDrop !== 1'b1)           begin n_fail++; $display("FAIL drop_set: got %b want 1", oDrop); end
    if (dut.hist_q[5] !== 20'd0)  begin n_fail++; $display("FAIL drop_hist5: got %0d want 0", dut.hist_q[5]); end
    if (dut.n_q !== 20'd16)       begin n_fail++; $display("FAIL drop_n: got %0d want 16", dut.n_q); end
    wait_pulse(p, l, th, dg);
    n_chk += 2;
    if (th !== 8'd20) begin n_fail++; $display("FAIL drop_thresh: got %0d want 20", th); end
    if (oDrop !== 1'b1) begin n_fail++; $display("FAIL drop_sticky: got %b want 1", oDrop); end
    wait_idle();
    vs_pulse();
    n_chk++;
    if (oDrop !== 1'b0) begin n_fail++; $display("FAIL drop_clear: got %b want 0", oDrop); end
    wait_pulse(p, l, th, dg);
    n_chk += 2;
    if (p != 0)        begin n_fail++; $display("FAIL empty_frame_pulses: got %0d want 0", p); end
    if (oBusy !== 1'b0) begin n_fail++; $display("FAIL empty_frame_busy: got %b want 0", oBusy); end
  endtask

  task automatic test_reset_mid_scan();
    int p, l; logic [7:0] th; logic dg; bit hit = 1'b0;
    wait_idle();
    send_px(8'd20, 8);
    send_px(8'd200, 8);
    vs_pulse();
    for (int i = 0; i < 600; i++) begin
      if (oBusy && dut.t_iss_q == 8'd100) begin hit = 1'b1; break; end
      tick();
    end
    n_chk++;
    if (!hit) begin n_fail++; $display("FAIL midscan_reach: bin 100 not reached, want reached"); end
    rst_n = 1'b0; tick();
    n_chk += 5;
    if (oThresh !== 8'd0)    begin n_fail++; $display("FAIL midscan_thresh: got %0d want 0", oThresh); end
    if (oThresh_valid !== 0) begin n_fail++; $display("FAIL midscan_valid: got %b want 0", oThresh_valid); end
    if (oDegenerate !== 0)   begin n_fail++; $display("FAIL midscan_degen: got %b want 0", oDegenerate); end
    if (oBusy !== 0)         begin n_fail++; $display("FAIL midscan_busy: got %b want 0", oBusy); end
    if (oDrop !== 0)         begin n_fail++; $display("FAIL midscan_drop: got %b want 0", oDrop); end
    rst_n = 1'b1; tick();
    n_chk++;
    if (oBusy !== 1'b1) begin n_fail++; $display("FAIL midscan_clear: busy got %b want 1", oBusy); end
    frame(8'd20, 8, 8'd200, 8, p, l, th, dg);
    n_chk += 3;
    if (th !== 8'd20) begin n_fail++; $display("FAIL midscan_next_thresh: got %0d want 20", th); end
    if (dg !== 1'b0)  begin n_fail++; $display("FAIL midscan_next_degen: got %b want 0", dg); end
    if (p != 1)       begin n_fail++; $display("FAIL midscan_next_pulses: got %0d want 1", p); end
  endtask

`ifdef OTSU_BIN_OUT_EN
  task automatic test_bin_out();
    logic [7:0] px[4]  = '{8'd20, 8'd21, 8'd0, 8'd255};
    logic [7:0] exp[4] = '{8'd0, 8'd255, 8'd0, 8'd255};
    logic       hv[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      iGray_orig = px[i]; de = 1'b1; hs = hv[i];
      tick();
      n_chk += 4;
      if (oBin !== exp[i]) begin n_fail++; $display("FAIL bin_%0d: got %0d want %0d", i, oBin, exp[i]); end
      if (oDe !== 1'b1)    begin n_fail++; $display("FAIL bin_de_%0d: got %b want 1", i, oDe); end
      if (oHs !== hv[i])   begin n_fail++; $display("FAIL bin_hs_%0d: got %b want %b", i, oHs, hv[i]); end
      if (oVs !== 1'b0)    begin n_fail++; $display("FAIL bin_vs_%0d: got %b want 0", i, oVs); end
    end
    de = 1'b0; hs = 1'b0; tick();
    n_chk++;
    if (oDe !== 1'b0) begin n_fail++; $display("FAIL bin_de_off: got %b want 0", oDe); end
  endtask
`endif

  initial begin
    test_reset();
    test_bimodal();
    test_hazard();
    test_uniform();
    test_drop();
    test_reset_mid_scan();
`ifdef OTSU_BIN_OUT_EN
    test_bin_out();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/otsu_thresh_core.md
Name: otsu_thresh_core

Overview:
- Parametrised successor to the fixed-width Otsu threshold unit.
- Builds a per-frame grey histogram from the video stream, runs an Otsu between-class-variance scan during vertical blanking, and publishes the optimal threshold.
- Generalised pixel width and pixel-count width, with status flags for degenerate frames and dropped pixels.
- Sits after the grey generator / NMS stage, feeding the binarisation stage.

Parameters:
- PIX_W, 8, grey pixel width; histogram has BINS = 2^PIX_W entries.
- CNT_W, 20, width of the per-bin count, the frame pixel count N, and w0.
- SUM_W, CNT_W+PIX_W, width of the weighted sums sumT and s0.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- iGray_orig  in  PIX_W  grey pixel; valid when de=1.
- hs  in  1  horizontal sync, active high.
- vs  in  1  vertical sync, active high; rising edge marks the frame boundary.
- de  in  1  data enable.
- oThresh  out  PIX_W  current threshold; pixels > oThresh are foreground.
- oThresh_valid  out  1  one-cycle pulse when oThresh updates.
- oDegenerate  out  1  set at scan end if no valid split exists; held until next scan end.
- oBusy  out  1  high during SCAN and CLEAR.
- oDrop  out  1  sticky; set if de=1 while oBusy=1; cleared at the next vs rising edge.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - All outputs go to 0.
  - FSM enters CLEAR.
  - N, sumT, s0 and w0 clear.
  - Reset mid-SCAN aborts the scan; oThresh returns to 0.
- FSM states: CLEAR -> ACCUM -> SCAN -> CLEAR.
- CLEAR:
  - Writes 0 to bins 0..BINS-1, one per cycle (BINS cycles).
  - Then goes to ACCUM; oBusy=1.
- ACCUM:
  - Per de=1 pixel: hist[p]++, N++, sumT += p.
  - Read-modify-write is pipelined with 1-cycle RAM read latency.
  - Back-to-back identical pixel values use a forwarding bypass, so every pixel counts exactly once.
  - Bin counts saturate at 2^CNT_W-1.
  - On vs rising edge with N>0, go to SCAN. With N=0, stay in ACCUM and do not pulse.
- SCAN:
  - Iterate t = 0..BINS-1, one bin per cycle; pipeline depth is free but at most 4 cycles.
  - Per bin: w0 += h(t), s0 += t*h(t), w1 = N - w0.
  - t is a candidate only if w0>0 and w1>0.
  - num = (sumT*w0 - N*s0)^2, computed on an unsigned magnitude; den = w0*w1.
  - Candidate replaces best if num*best_den > best_num*den, evaluated at full product width with no truncation.
  - Comparison is strict, so the lowest t wins ties. best_num and best_den are initialised to 0 and 1.
  - At scan end with a candidate found: oThresh <= best t, oThresh_valid pulses 1 cycle, oDegenerate <= 0.
  - With no candidate (all pixels equal): oThresh holds, oThresh_valid pulses, oDegenerate <= 1.
  - Then go to CLEAR.
- Busy period:
  - Total busy time is BINS + scan latency + BINS cycles, at most 2*BINS+8.
  - Vertical blanking must exceed this.
  - Pixels arriving while busy are ignored and set oDrop.
- A vs rising edge during SCAN or CLEAR is ignored.
- hs is not used for computation; it is only forwarded under the optional feature.

Optional Feature:
- Macro: OTSU_BIN_OUT_EN.
- Defined:
  - Adds outputs oBin (PIX_W), oHs, oVs and oDe.
  - oBin = all-ones if iGray_orig > oThresh, else 0.
  - Output is registered with 1-cycle latency, and syncs are delayed to match.
  - The threshold used is the value of oThresh sampled in the same cycle as the pixel.
  - All four outputs are 0 in reset.
- Undefined: these ports and their logic do not exist; the rest of the behaviour is identical.

Test Plan:
- Bimodal frame, PIX_W=8: 8 pixels of 20 then 8 pixels of 200, then vs rise.
  - Expect oThresh=20 after at most 2*256+8 cycles, oThresh_valid one pulse, oDegenerate=0.
- Hazard frame: 12 consecutive pixels of 10, then 4 of 250.
  - Expect oThresh=10.
  - Expect the internal N=16 and hist[10]=12 probed via hierarchy, confirming the bypass.
- Uniform frame: 16 pixels of 77.
  - Expect oThresh stays 0 from reset, oThresh_valid pulses, oDegenerate=1.
  - A following bimodal frame (20/200) gives oThresh=20 and oDegenerate=0.
- Drop: assert de with pixel 5 during SCAN.
  - Expect oDrop=1, histogram unaffected, threshold result unchanged.
  - oDrop clears on the next vs rise.
- Reset mid-SCAN: drop rst_n for 1 cycle at scan bin 100.
  - Expect all outputs 0 and CLEAR restart.
  - Next bimodal frame yields 20 with no stale data.
- With OTSU_BIN_OUT_EN and oThresh=20: input pixels 20, 21, 0, 255.
  - Expect oBin = 0, 255, 0, 255, one cycle later.
  - oDe, oHs and oVs match the inputs delayed 1 cycle.
